// File: rtl/uarc_bus_receiver_if.sv
`default_nettype none
// ============================================================================
// Module   : uarc_bus_receiver_if
// Brief    : UARC receiver lane signals: sender bus side plus local dispatch side.
// Revision : 1.0
// ============================================================================
interface uarc_bus_receiver_if #(
  parameter int WORD_MAG  = 5,
  parameter int DEPTH_MAG = 2
);
  localparam int c_WORD_WIDTH = 1 << WORD_MAG;

  logic                    bus_valid;
  logic [c_WORD_WIDTH-1:0] bus_pc;
  logic [c_WORD_WIDTH-1:0] bus_data;
  logic                    bus_accept;
  logic                    flush;
  logic                    msg_valid;
  logic [c_WORD_WIDTH-1:0] msg_pc;
  logic [c_WORD_WIDTH-1:0] msg_data;
  logic                    msg_take;
  logic [DEPTH_MAG:0]      count;

  // master: remote sender plus local core; slave: the receiver itself
  modport master (
    output bus_valid, bus_pc, bus_data, flush, msg_take,
    input  bus_accept, msg_valid, msg_pc, msg_data, count
  );

  modport slave (
    input  bus_valid, bus_pc, bus_data, flush, msg_take,
    output bus_accept, msg_valid, msg_pc, msg_data, count
  );
endinterface
`default_nettype wire

// File: rtl/uarc_bus_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uarc_bus_receiver
// Brief    : UARC bus receiving endpoint; buffers {pc,data} messages in a
//            first-word-fall-through FIFO with registered back-pressure.
// Revision : 1.0
// ============================================================================
module uarc_bus_receiver #(
  parameter int WORD_MAG  = 5,
  parameter int DEPTH_MAG = 2
) (
  input  wire                    clk,
  input  wire                    reset,
  uarc_bus_receiver_if.slave     bus
);
  localparam int                 c_WORD_WIDTH = 1 << WORD_MAG;
  localparam int                 c_DEPTH      = 1 << DEPTH_MAG;
  localparam logic [DEPTH_MAG:0] c_DEPTH_CNT  = (DEPTH_MAG+1)'(c_DEPTH);
  localparam logic [DEPTH_MAG:0] c_CNT_ONE    = (DEPTH_MAG+1)'(1);
  localparam logic [DEPTH_MAG-1:0] c_PTR_ONE  = DEPTH_MAG'(1);

  logic [c_WORD_WIDTH-1:0] r_pc_mem   [c_DEPTH];
  logic [c_WORD_WIDTH-1:0] r_data_mem [c_DEPTH];
  logic [DEPTH_MAG-1:0]    r_wp;
  logic [DEPTH_MAG-1:0]    r_rp;
  logic [DEPTH_MAG:0]      r_count;
  logic                    r_accept;

  logic                    w_accept;
  logic                    w_msg_valid;
  logic                    w_push;
  logic                    w_pop;
  logic [DEPTH_MAG:0]      w_count_next;

  // Flush masks both sides of the FIFO for the cycle it is asserted.
  assign w_accept    = r_accept && !bus.flush;
  assign w_msg_valid = (r_count != '0);
  assign w_push      = bus.bus_valid && w_accept;
  assign w_pop       = w_msg_valid && bus.msg_take && !bus.flush;

  always_comb begin
    w_count_next = r_count;
    if (bus.flush) begin
      w_count_next = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_next = r_count + c_CNT_ONE;
        2'b01:   w_count_next = r_count - c_CNT_ONE;
        default: w_count_next = r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_count  <= '0;
      r_accept <= 1'b0;
    end else begin
      r_count  <= w_count_next;
      // No pass-through: a pop from full only reopens the bus a cycle later.
      r_accept <= (w_count_next < c_DEPTH_CNT);
      if (bus.flush) begin
        r_wp <= '0;
        r_rp <= '0;
      end else begin
        if (w_push) r_wp <= r_wp + c_PTR_ONE;
        if (w_pop)  r_rp <= r_rp + c_PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wp]   <= bus.bus_pc;
      r_data_mem[r_wp] <= bus.bus_data;
    end
  end

  assign bus.bus_accept = w_accept;
  assign bus.msg_valid  = w_msg_valid;
  assign bus.msg_pc     = r_pc_mem[r_rp];
  assign bus.msg_data   = r_data_mem[r_rp];
  assign bus.count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uarc_bus_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_uarc_bus_receiver
// Brief    : Directed self-checking bench for uarc_bus_receiver (WORD_MAG=5, DEPTH_MAG=2).
// Revision : 1.0
// ============================================================================
module tb_uarc_bus_receiver;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  uarc_bus_receiver_if #(.WORD_MAG(5), .DEPTH_MAG(2)) bus_if ();

  uarc_bus_receiver #(.WORD_MAG(5), .DEPTH_MAG(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance through one rising edge and settle on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] d,
                       input logic take, input logic fl);
    bus_if.bus_valid = v;
    bus_if.bus_pc    = pc;
    bus_if.bus_data  = d;
    bus_if.msg_take  = take;
    bus_if.flush     = fl;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    drive(1'b1, 32'h99, 32'h77, 1'b0, 1'b0);

    // Reset held with the sender active
    repeat (3) step();
    chk("rst_accept", {31'd0, bus_if.bus_accept}, 32'd0);
    chk("rst_count",  {29'd0, bus_if.count},      32'd0);
    chk("rst_valid",  {31'd0, bus_if.msg_valid},  32'd0);
    reset = 1'b1;
    #1;
    chk("rel_accept_before_edge", {31'd0, bus_if.bus_accept}, 32'd0);
    step();
    chk("rel_accept_after_edge", {31'd0, bus_if.bus_accept}, 32'd1);
    chk("rel_count",  {29'd0, bus_if.count},     32'd0);
    chk("rel_valid",  {31'd0, bus_if.msg_valid}, 32'd0);

    // Fill to full
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h10 + i, 32'hA0 + i, 1'b0, 1'b0);
      step();
      chk($sformatf("fill_count%0d", i), {29'd0, bus_if.count}, i + 1);
    end
    chk("full_accept", {31'd0, bus_if.bus_accept}, 32'd0);
    chk("full_head",   bus_if.msg_pc, 32'h10);
    drive(1'b1, 32'h14, 32'hA4, 1'b0, 1'b0);
    step();
    chk("held_count", {29'd0, bus_if.count}, 32'd4);

    // Pop from full with a push pending: pop only, bus reopens next cycle
    drive(1'b1, 32'h14, 32'hA4, 1'b1, 1'b0);
    chk("fullpop_accept", {31'd0, bus_if.bus_accept}, 32'd0);
    chk("fullpop_head_data", bus_if.msg_data, 32'hA0);
    step();
    chk("fullpop_count", {29'd0, bus_if.count}, 32'd3);
    chk("fullpop_reopen", {31'd0, bus_if.bus_accept}, 32'd1);
    chk("fullpop_next_head", bus_if.msg_pc, 32'h11);
    drive(1'b1, 32'h14, 32'hA4, 1'b0, 1'b0);
    step();
    chk("held_lands_count", {29'd0, bus_if.count}, 32'd4);

    // Drain in order
    for (int i = 1; i < 5; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk($sformatf("drain_valid%0d", i), {31'd0, bus_if.msg_valid}, 32'd1);
      chk($sformatf("drain_pc%0d", i),   bus_if.msg_pc,   32'h10 + i);
      chk($sformatf("drain_data%0d", i), bus_if.msg_data, 32'hA0 + i);
      step();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("drained_count", {29'd0, bus_if.count},     32'd0);
    chk("drained_valid", {31'd0, bus_if.msg_valid}, 32'd0);

    // Steady state at count 1; pointers wrap
    drive(1'b1, 32'h20, 32'hB0, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 32'h21 + k, 32'hB1 + k, 1'b1, 1'b0);
      chk($sformatf("wrap_head%0d", k), bus_if.msg_pc, 32'h20 + k);
      step();
      chk($sformatf("wrap_count%0d", k), {29'd0, bus_if.count}, 32'd1);
    end
    chk("wrap_last_pc",   bus_if.msg_pc,   32'h26);
    chk("wrap_last_data", bus_if.msg_data, 32'hB6);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    chk("wrap_empty", {29'd0, bus_if.count}, 32'd0);

    // Flush dominates concurrent push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h30 + i, 32'hC0 + i, 1'b0, 1'b0);
      step();
    end
    chk("preflush_count", {29'd0, bus_if.count}, 32'd3);
    drive(1'b1, 32'h33, 32'hC3, 1'b1, 1'b1);
    chk("flush_accept", {31'd0, bus_if.bus_accept}, 32'd0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("flush_count",  {29'd0, bus_if.count},      32'd0);
    chk("flush_valid",  {31'd0, bus_if.msg_valid},  32'd0);
    chk("flush_reopen", {31'd0, bus_if.bus_accept}, 32'd1);

    // Asynchronous reset between edges
    drive(1'b1, 32'h40, 32'hD0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h41, 32'hD1, 1'b0, 1'b0);
    step();
    chk("prerst_count", {29'd0, bus_if.count}, 32'd2);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1 reset = 1'b0;
    #1;
    chk("arst_count",  {29'd0, bus_if.count},      32'd0);
    chk("arst_valid",  {31'd0, bus_if.msg_valid},  32'd0);
    chk("arst_accept", {31'd0, bus_if.bus_accept}, 32'd0);
    step();
    reset = 1'b1;
    step();
    drive(1'b1, 32'h55, 32'h66, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("post_rst_count", {29'd0, bus_if.count},     32'd1);
    chk("post_rst_valid", {31'd0, bus_if.msg_valid}, 32'd1);
    chk("post_rst_pc",    bus_if.msg_pc,   32'h55);
    chk("post_rst_data",  bus_if.msg_data, 32'h66);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/uarc_bus_receiver.md
# uarc_bus_receiver

Receiving endpoint of a single UARC bus: accepts messages (program-counter word plus one data word) from a remote core's sender port and buffers them in a small FIFO until the local core's dispatch logic takes them. One instance sits on each receiver lane of a core; it provides the buffering and back-pressure that the sender side depends on. Bus width follows WORD_MAG, matching the core word width.

## Interface
- WORD_MAG, 5, log2 of the word width; WORD_WIDTH = 1 << WORD_MAG
- DEPTH_MAG, 2, log2 of FIFO depth; DEPTH = 1 << DEPTH_MAG messages

- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- bus_valid  input  1  sender presents a message this cycle
- bus_pc  input  WORD_WIDTH  target program counter of the message
- bus_data  input  WORD_WIDTH  message payload word
- bus_accept  output  1  receiver takes the message when bus_valid is also high
- flush  input  1  discard all buffered messages (synchronous)
- msg_valid  output  1  head message available
- msg_pc  output  WORD_WIDTH  head message PC
- msg_data  output  WORD_WIDTH  head message payload
- msg_take  input  1  core consumes head message when msg_valid is also high
- count  output  DEPTH_MAG+1  messages currently buffered (0..DEPTH)

## Operation
- Storage: DEPTH entries of {pc, data}; write pointer wp and read pointer rp, each DEPTH_MAG bits, wrapping modulo DEPTH; occupancy held in count register.
- Push: bus_valid && bus_accept. Writes {bus_pc, bus_data} at wp, wp+1.
- Pop: msg_valid && msg_take. rp+1. msg_take with msg_valid low is ignored.
- Simultaneous push and pop: both happen; count unchanged.
- Full (count == DEPTH): bus_accept low; no pass-through, so push is blocked even if a pop occurs that same cycle.
- Empty (count == 0): msg_valid low; msg_pc/msg_data don't-care (hold stale entry, not checked).
- Flush: highest priority. In a flush cycle bus_accept is forced low, any pop is discarded, and at the edge wp, rp, count go to 0. Storage contents not cleared.
- bus_accept = accept_q && !flush, where accept_q is a register loaded each edge with (count_next < DEPTH). accept_q is 0 after a flush edge is not required; accept_q = 1 after flush (count_next = 0).
- First-word fall-through: msg_pc/msg_data are the entry at rp read combinationally; msg_valid = (count != 0).
- Sender contract: bus_pc/bus_data must be stable while bus_valid is high and bus_accept is low; the receiver does not check this.

## Timing
- Reset (reset == 0, asynchronous): wp = rp = 0, count = 0, accept_q = 0. Outputs: bus_accept 0, msg_valid 0, count 0.
- First rising edge after reset deasserts: accept_q becomes 1. bus_accept first high in the following cycle. No message is accepted in the cycle reset releases.
- Push-to-output latency: 1 cycle. Message pushed at edge N is visible on msg_valid/msg_pc/msg_data after edge N.
- Pop: head advances at the edge where msg_take && msg_valid; next entry is visible immediately after that edge.
- Back-pressure: the push that makes count reach DEPTH drops bus_accept after the same edge. A pop from full raises bus_accept one cycle later (registered), so there is a one-cycle bubble.
- Reset asserted mid-transfer: all state cleared immediately; in-flight and buffered messages are lost; the sender must re-send after reset.
- Sustained throughput: 1 message/cycle when neither full nor empty.

## Test plan
- Reset release: hold reset=0 with bus_valid=1 for 3 cycles, then release -> bus_accept 0 until the first edge after release, then 1; count 0; msg_valid 0; no push recorded.
- Fill/drain order (WORD_MAG=5, DEPTH_MAG=2): push pc=0x10..0x13 with data=0xA0..0xA3, msg_take=0 -> count 4, bus_accept 0 after the 4th edge; a 5th push of pc=0x14 is held. Then take 4 -> heads appear in order 0x10..0x13; count 0.
- Wrap-around: 6 push/pop pairs at count=1 steady -> pointers wrap past 3; every msg_pc equals the pushed value one cycle later; count stays 1.
- Full plus simultaneous pop: at count 4, assert bus_valid and msg_take for one cycle -> pop only, count 3; bus_accept high next cycle; the held push then lands, count 4.
- Flush priority: at count 3 assert flush with bus_valid=1 and msg_take=1 -> bus_accept 0 in that cycle, count 0 after the edge, msg_valid 0, bus_accept 1 the next cycle.
- Async reset mid-stream: assert reset between edges at count 2 -> count, msg_valid, and bus_accept drop to 0 without waiting for a clock edge; after release, the first push of pc=0x55 is the first head.
